// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: LSU op codes, data-bus commands,
// FSM state encodings and the alignment rule.
package mem_access_pkg;

   localparam int LSUOP_W = 2;

   localparam logic [1:0] LSU_IDLE = 2'd0;
   localparam logic [1:0] LSU_BYTE = 2'd1;
   localparam logic [1:0] LSU_HALF = 2'd2;
   localparam logic [1:0] LSU_WORD = 2'd3;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Byte accesses are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
      return ((op == LSU_HALF) && addr_lo[0]) || ((op == LSU_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store-side lane replication and byte
// enables, load-side lane extraction with sign/zero extension (little-endian).
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            st_op,
   input  logic [1:0]            st_addr,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic [3:0]            st_ben,
   output logic [DATA_WIDTH-1:0] st_wdata,
   input  logic [1:0]            ld_op,
   input  logic [1:0]            ld_addr,
   input  logic                  ld_ext,
   input  logic [DATA_WIDTH-1:0] ld_rdata,
   output logic [DATA_WIDTH-1:0] ld_val
);

   logic [7:0]  lane8;
   logic [15:0] lane16;

   always_comb begin
      st_ben   = 4'b0000;
      st_wdata = '0;
      case (st_op)
         LSU_BYTE: begin
            st_ben   = 4'b0001 << st_addr;
            st_wdata = {(DATA_WIDTH/8){st_data[7:0]}};
         end
         LSU_HALF: begin
            st_ben   = st_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {(DATA_WIDTH/16){st_data[15:0]}};
         end
         LSU_WORD: begin
            st_ben   = 4'b1111;
            st_wdata = st_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      lane8  = ld_rdata[{ld_addr, 3'b000} +: 8];
      lane16 = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      ld_val = '0;
      case (ld_op)
         LSU_BYTE: ld_val = {{(DATA_WIDTH-8){ld_ext & lane8[7]}}, lane8};
         LSU_HALF: ld_val = {{(DATA_WIDTH-16){ld_ext & lane16[15]}}, lane16};
         LSU_WORD: ld_val = ld_rdata;
         default:  ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues LSU loads/stores on the data bus, stalls
// upstream while the bus is busy, and forwards the register write to writeback.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int REGNO_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   i_exec_stall,
   input  logic                   i_fetch_stall,
   output logic                   o_mem_stall,
   output logic                   o_addr_error,
   input  logic [REGNO_WIDTH-1:0] i_rd_no,
   input  logic [DATA_WIDTH-1:0]  i_alu_result,
   input  logic [LSUOP_W-1:0]     i_lsu_op,
   input  logic                   i_lsu_lns,
   input  logic                   i_lsu_ext,
   input  logic [DATA_WIDTH-1:0]  i_mem_data,
   output logic [ADDR_WIDTH-1:0]  o_dbus_addr,
   output logic [1:0]             o_dbus_cmd,
   output logic [3:0]             o_dbus_ben,
   output logic [DATA_WIDTH-1:0]  o_dbus_wdata,
   input  logic                   i_dbus_ack,
   input  logic [DATA_WIDTH-1:0]  i_dbus_rdata,
   input  logic                   i_dbus_rvalid,
   output logic [REGNO_WIDTH-1:0] o_rd_no,
   output logic [DATA_WIDTH-1:0]  o_rd_val
);

   logic [1:0]             state;
   logic [ADDR_WIDTH-1:0]  a_addr;
   logic [LSUOP_W-1:0]     a_op;
   logic                   a_lns;
   logic                   a_ext;
   logic [REGNO_WIDTH-1:0] a_rd_no;
   logic [3:0]             a_ben;
   logic [DATA_WIDTH-1:0]  a_wdata;
   logic [REGNO_WIDTH-1:0] h_rd_no;
   logic [DATA_WIDTH-1:0]  h_rd_val;

   logic                   op_valid, misaligned, other_stall, core_stall, done_now;
   logic [3:0]             st_ben;
   logic [DATA_WIDTH-1:0]  st_wdata, ld_val;
   logic [REGNO_WIDTH-1:0] res_rd_no;
   logic [DATA_WIDTH-1:0]  res_rd_val;

   assign op_valid    = (i_lsu_op != LSU_IDLE);
   assign misaligned  = is_misaligned(i_lsu_op, i_alu_result[1:0]);
   assign other_stall = i_exec_stall | i_fetch_stall;
   assign core_stall  = other_stall | o_mem_stall;

   // Load completes on rvalid, which may coincide with the ack; stores on ack alone.
   assign done_now = ((state == ST_CMD) && i_dbus_ack && (!a_lns || i_dbus_rvalid)) ||
                     ((state == ST_WAIT) && i_dbus_rvalid);

   assign o_mem_stall = ((state == ST_IDLE) && op_valid && !misaligned) ||
                        (((state == ST_CMD) || (state == ST_WAIT)) && !done_now);

   assign o_dbus_cmd   = (state == ST_CMD) ? (a_lns ? CMD_READ : CMD_WRITE) : CMD_NONE;
   assign o_dbus_addr  = (state == ST_CMD) ? {a_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign o_dbus_ben   = (state == ST_CMD) ? a_ben : 4'b0000;
   assign o_dbus_wdata = (state == ST_CMD) ? a_wdata : '0;

   assign res_rd_no  = a_lns ? a_rd_no : '0;
   assign res_rd_val = a_lns ? ld_val : '0;

   mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .st_op    (i_lsu_op),
      .st_addr  (i_alu_result[1:0]),
      .st_data  (i_mem_data),
      .st_ben   (st_ben),
      .st_wdata (st_wdata),
      .ld_op    (a_op),
      .ld_addr  (a_addr[1:0]),
      .ld_ext   (a_ext),
      .ld_rdata (i_dbus_rdata),
      .ld_val   (ld_val)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= ST_IDLE;
         a_addr       <= '0;
         a_op         <= LSU_IDLE;
         a_lns        <= 1'b0;
         a_ext        <= 1'b0;
         a_rd_no      <= '0;
         a_ben        <= 4'b0000;
         a_wdata      <= '0;
         h_rd_no      <= '0;
         h_rd_val     <= '0;
         o_rd_no      <= '0;
         o_rd_val     <= '0;
         o_addr_error <= 1'b0;
      end else begin
         o_addr_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (op_valid && !misaligned) begin
                  // Latch regardless of other_stall: the op is held upstream by our stall.
                  a_addr  <= i_alu_result[ADDR_WIDTH-1:0];
                  a_op    <= i_lsu_op;
                  a_lns   <= i_lsu_lns;
                  a_ext   <= i_lsu_ext;
                  a_rd_no <= i_rd_no;
                  a_ben   <= st_ben;
                  a_wdata <= st_wdata;
                  state   <= ST_CMD;
               end else if (!core_stall) begin
                  if (op_valid) begin
                     o_addr_error <= 1'b1;
                     o_rd_no      <= '0;
                  end else begin
                     o_rd_no  <= i_rd_no;
                     o_rd_val <= i_alu_result;
                  end
               end
            end
            ST_CMD, ST_WAIT: begin
               if (done_now) begin
                  if (!other_stall) begin
                     o_rd_no  <= res_rd_no;
                     o_rd_val <= res_rd_val;
                     state    <= ST_IDLE;
                  end else begin
                     h_rd_no  <= res_rd_no;
                     h_rd_val <= res_rd_val;
                     state    <= ST_DONE;
                  end
               end else if ((state == ST_CMD) && i_dbus_ack) begin
                  state <= ST_WAIT;
               end
            end
            ST_DONE: begin
               if (!other_stall) begin
                  o_rd_no  <= h_rd_no;
                  o_rd_val <= h_rd_val;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, store/load lanes, misalignment,
// downstream stall during completion, and reset in the middle of a load.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic        i_exec_stall, i_fetch_stall;
   logic        o_mem_stall, o_addr_error;
   logic [4:0]  i_rd_no;
   logic [31:0] i_alu_result;
   logic [1:0]  i_lsu_op;
   logic        i_lsu_lns, i_lsu_ext;
   logic [31:0] i_mem_data;
   logic [31:0] o_dbus_addr;
   logic [1:0]  o_dbus_cmd;
   logic [3:0]  o_dbus_ben;
   logic [31:0] o_dbus_wdata;
   logic        i_dbus_ack;
   logic [31:0] i_dbus_rdata;
   logic        i_dbus_rvalid;
   logic [4:0]  o_rd_no;
   logic [31:0] o_rd_val;

   int n_chk  = 0;
   int n_fail = 0;
   int read_cnt = 0;
   int rc0;

   mem_access dut (
      .clk(clk), .nrst(nrst),
      .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall),
      .o_mem_stall(o_mem_stall), .o_addr_error(o_addr_error),
      .i_rd_no(i_rd_no), .i_alu_result(i_alu_result),
      .i_lsu_op(i_lsu_op), .i_lsu_lns(i_lsu_lns), .i_lsu_ext(i_lsu_ext),
      .i_mem_data(i_mem_data),
      .o_dbus_addr(o_dbus_addr), .o_dbus_cmd(o_dbus_cmd), .o_dbus_ben(o_dbus_ben),
      .o_dbus_wdata(o_dbus_wdata),
      .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata), .i_dbus_rvalid(i_dbus_rvalid),
      .o_rd_no(o_rd_no), .o_rd_val(o_rd_val)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (o_dbus_cmd == CMD_READ) read_cnt <= read_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [1:0] o, input logic lns, input logic ext,
                     input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
      i_lsu_op = o; i_lsu_lns = lns; i_lsu_ext = ext;
      i_alu_result = addr; i_mem_data = data; i_rd_no = rd;
   endtask

   initial begin
      nrst = 1'b0; i_exec_stall = 1'b0; i_fetch_stall = 1'b0;
      op(LSU_IDLE, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      i_dbus_ack = 1'b0; i_dbus_rdata = 32'h0; i_dbus_rvalid = 1'b0;
      tick(); tick();

      chk("rst_rd_no",  32'(o_rd_no), 32'd0);
      chk("rst_rd_val", o_rd_val, 32'h0);
      chk("rst_cmd",    32'(o_dbus_cmd), 32'(CMD_NONE));
      chk("rst_addr",   o_dbus_addr, 32'h0);
      chk("rst_ben",    32'(o_dbus_ben), 32'h0);
      chk("rst_err",    32'(o_addr_error), 32'd0);
      chk("rst_stall",  32'(o_mem_stall), 32'd0);
      nrst = 1'b1;

      // Non-LSU pass-through
      op(LSU_IDLE, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7); #1;
      chk("pt_stall", 32'(o_mem_stall), 32'd0);
      tick();
      chk("pt_rd_no",  32'(o_rd_no), 32'd7);
      chk("pt_rd_val", o_rd_val, 32'h1234);
      chk("pt_cmd",    32'(o_dbus_cmd), 32'(CMD_NONE));

      // Store byte at 0x103, ack on the second CMD cycle
      op(LSU_BYTE, 1'b0, 1'b0, 32'h103, 32'hAABBCCDD, 5'd9); #1;
      chk("sb_stall0", 32'(o_mem_stall), 32'd1);
      tick();
      chk("sb_cmd",   32'(o_dbus_cmd), 32'(CMD_WRITE));
      chk("sb_addr",  o_dbus_addr, 32'h100);
      chk("sb_ben",   32'(o_dbus_ben), 32'b1000);
      chk("sb_wdata", o_dbus_wdata, 32'hDDDDDDDD);
      chk("sb_stall1", 32'(o_mem_stall), 32'd1);
      tick();
      chk("sb_cmd_held", 32'(o_dbus_cmd), 32'(CMD_WRITE));
      chk("sb_stall2",   32'(o_mem_stall), 32'd1);
      i_dbus_ack = 1'b1; #1;
      chk("sb_stall_ack", 32'(o_mem_stall), 32'd0);
      tick();
      i_dbus_ack = 1'b0;
      chk("sb_rd_no", 32'(o_rd_no), 32'd0);
      chk("sb_cmd_end", 32'(o_dbus_cmd), 32'(CMD_NONE));

      // Signed half load at 0x202, rvalid one cycle after ack
      op(LSU_HALF, 1'b1, 1'b1, 32'h202, 32'h0, 5'd5);
      tick();
      chk("lh_cmd",  32'(o_dbus_cmd), 32'(CMD_READ));
      chk("lh_addr", o_dbus_addr, 32'h200);
      chk("lh_ben",  32'(o_dbus_ben), 32'b1100);
      i_dbus_ack = 1'b1;
      tick();
      i_dbus_ack = 1'b0;
      chk("lh_wait_cmd",   32'(o_dbus_cmd), 32'(CMD_NONE));
      chk("lh_wait_stall", 32'(o_mem_stall), 32'd1);
      i_dbus_rvalid = 1'b1; i_dbus_rdata = 32'h8001FFFF; #1;
      chk("lh_done_stall", 32'(o_mem_stall), 32'd0);
      tick();
      i_dbus_rvalid = 1'b0;
      chk("lh_rd_no",  32'(o_rd_no), 32'd5);
      chk("lh_rd_val", o_rd_val, 32'hFFFF8001);

      // Same half load zero-extended, ack and rvalid together
      op(LSU_HALF, 1'b1, 1'b0, 32'h202, 32'h0, 5'd6);
      tick();
      i_dbus_ack = 1'b1; i_dbus_rvalid = 1'b1; #1;
      chk("lhu_stall", 32'(o_mem_stall), 32'd0);
      tick();
      i_dbus_ack = 1'b0; i_dbus_rvalid = 1'b0;
      chk("lhu_rd_no",  32'(o_rd_no), 32'd6);
      chk("lhu_rd_val", o_rd_val, 32'h00008001);

      // Misaligned word load
      op(LSU_WORD, 1'b1, 1'b0, 32'h301, 32'h0, 5'd3); #1;
      chk("mis_stall", 32'(o_mem_stall), 32'd0);
      chk("mis_cmd0",  32'(o_dbus_cmd), 32'(CMD_NONE));
      tick();
      chk("mis_err",   32'(o_addr_error), 32'd1);
      chk("mis_rd_no", 32'(o_rd_no), 32'd0);
      chk("mis_cmd1",  32'(o_dbus_cmd), 32'(CMD_NONE));
      op(LSU_IDLE, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
      chk("mis_err_clr", 32'(o_addr_error), 32'd0);

      // Word load completing under a 3-cycle exec stall
      rc0 = read_cnt;
      op(LSU_WORD, 1'b1, 1'b0, 32'h400, 32'h0, 5'd10);
      tick();
      i_dbus_ack = 1'b1;
      tick();
      i_dbus_ack = 1'b0;
      i_exec_stall = 1'b1; i_dbus_rvalid = 1'b1; i_dbus_rdata = 32'hCAFEF00D; #1;
      chk("ds_stall_done", 32'(o_mem_stall), 32'd0);
      tick();
      i_dbus_rvalid = 1'b0; i_dbus_rdata = 32'h0;
      chk("ds_hold_rd_no", 32'(o_rd_no), 32'd0);
      chk("ds_hold_stall", 32'(o_mem_stall), 32'd0);
      chk("ds_hold_cmd",   32'(o_dbus_cmd), 32'(CMD_NONE));
      tick();
      chk("ds_hold2_rd_no", 32'(o_rd_no), 32'd0);
      chk("ds_hold2_cmd",   32'(o_dbus_cmd), 32'(CMD_NONE));
      tick();
      i_exec_stall = 1'b0;
      tick();
      chk("ds_rd_no",  32'(o_rd_no), 32'd10);
      chk("ds_rd_val", o_rd_val, 32'hCAFEF00D);
      chk("ds_reads",  32'(read_cnt - rc0), 32'd1);
      op(LSU_IDLE, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

      // Reset while waiting for read data, then a normal signed byte load
      op(LSU_BYTE, 1'b1, 1'b1, 32'h501, 32'h0, 5'd12);
      tick();
      i_dbus_ack = 1'b1;
      tick();
      i_dbus_ack = 1'b0;
      nrst = 1'b0;
      op(LSU_IDLE, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
      chk("rw_rd_no",  32'(o_rd_no), 32'd0);
      chk("rw_rd_val", o_rd_val, 32'h0);
      chk("rw_cmd",    32'(o_dbus_cmd), 32'(CMD_NONE));
      chk("rw_stall",  32'(o_mem_stall), 32'd0);
      nrst = 1'b1;
      op(LSU_BYTE, 1'b1, 1'b1, 32'h501, 32'h0, 5'd12);
      tick();
      chk("rl_cmd",  32'(o_dbus_cmd), 32'(CMD_READ));
      chk("rl_addr", o_dbus_addr, 32'h500);
      chk("rl_ben",  32'(o_dbus_ben), 32'b0010);
      i_dbus_ack = 1'b1;
      tick();
      i_dbus_ack = 1'b0;
      i_dbus_rvalid = 1'b1; i_dbus_rdata = 32'h00008000;
      tick();
      i_dbus_rvalid = 1'b0;
      op(LSU_IDLE, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("rl_rd_no",  32'(o_rd_no), 32'd12);
      chk("rl_rd_val", o_rd_val, 32'hFFFFFF80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage: the consumer of the execute stage's LSU outputs.
- Takes the LSU op, effective address (execute ALU result), store data and destination register number.
- Performs the load/store on the CPU data bus, handling byte lanes and sign/zero extension.
- Drives the stage stall back into the pipeline and forwards the register write (rd number/value) to writeback.

Parameters:
- ADDR_WIDTH, 32, address width (matches CPU address width).
- DATA_WIDTH, 32, data/register width.
- REGNO_WIDTH, 5, register-number width.

Ports:
- clk  in  1  core clock
- nrst  in  1  reset, synchronous, active-low
- i_exec_stall  in  1  execute-stage stall
- i_fetch_stall  in  1  fetch-stage stall
- o_mem_stall  out  1  this stage busy; holds upstream stages
- o_addr_error  out  1  misaligned access, one-cycle pulse
- i_rd_no  in  REGNO_WIDTH  destination register from execute
- i_alu_result  in  DATA_WIDTH  effective address, or result to pass through
- i_lsu_op  in  LSUOP width  IDLE/BYTE/HALF/WORD
- i_lsu_lns  in  1  1=load, 0=store
- i_lsu_ext  in  1  1=sign-extend load, 0=zero-extend
- i_mem_data  in  DATA_WIDTH  store data (unshifted rt value)
- o_dbus_addr  out  ADDR_WIDTH  word-aligned bus address
- o_dbus_cmd  out  2  NONE/READ/WRITE
- o_dbus_ben  out  4  byte enables
- o_dbus_wdata  out  DATA_WIDTH  write data, lane-replicated
- i_dbus_ack  in  1  command accepted this cycle
- i_dbus_rdata  in  DATA_WIDTH  read data
- i_dbus_rvalid  in  1  read data valid
- o_rd_no  out  REGNO_WIDTH  writeback register (R0 = no write)
- o_rd_val  out  DATA_WIDTH  writeback value

Behaviour:
- Reset (nrst low at clk edge): state IDLE; o_rd_no=0, o_rd_val=0, o_dbus_cmd=NONE, o_dbus_addr/ben/wdata=0, o_addr_error=0. A reset mid-transaction drops it; the bus agent must tolerate abandoned commands.
- Definitions:
  - op_valid = i_lsu_op!=IDLE.
  - misaligned = (HALF && addr[0]) || (WORD && addr[1:0]!=0).
  - other_stall = i_exec_stall||i_fetch_stall.
  - core_stall = other_stall||o_mem_stall.
- Non-LSU instruction (op IDLE): pass-through with 1-cycle latency. On each edge with !core_stall: o_rd_no<=i_rd_no, o_rd_val<=i_alu_result.
- Misaligned op: no bus command; o_mem_stall stays low. At the next edge with !core_stall: o_addr_error<=1 for one cycle, o_rd_no<=0. Otherwise o_addr_error<=0.
- FSM states IDLE, CMD, WAIT, DONE:
  - IDLE: if op_valid && !misaligned, o_mem_stall=1 combinationally in the same cycle; latch addr/size/ext/rd_no/lane data; go CMD. Latching happens even when other_stall is high.
  - CMD: drive o_dbus_cmd (READ if load, else WRITE) plus addr/ben/wdata, held stable until i_dbus_ack.
    - Store + ack: complete.
    - Load + ack: go WAIT, cmd=NONE. If i_dbus_rvalid arrives in the same cycle as ack, complete immediately.
  - WAIT: i_dbus_rvalid completes the load.
  - Completion cycle: o_mem_stall=0.
    - If !other_stall: write o_rd_no/o_rd_val (store: o_rd_no<=0) and go IDLE.
    - Otherwise capture the result in a hold register, go DONE.
  - DONE: o_mem_stall=0, no bus activity. When !other_stall, commit the held result, go IDLE. The op must never be reissued while upstream holds it.
- o_mem_stall: 1 in IDLE-with-new-op, CMD and WAIT, except the completion cycle.
- Byte lanes (little-endian, lane k = bits 8k+7:8k):
  - BYTE: ben=1<<addr[1:0]; wdata={4{d[7:0]}}.
  - HALF: ben=addr[1]?1100:0011; wdata={2{d[15:0]}}.
  - WORD: ben=1111, wdata=d.
  - o_dbus_addr = {addr[31:2],2'b00}.
- Loads: select lane(s) by addr[1:0], then sign-extend if ext, else zero-extend.
- Latency with ack in first CMD cycle, no other stall:
  - Store: 2 cycles presentation to commit.
  - Load with rvalid one cycle after ack: 3 cycles.

Decomposition:
- Shared constants header (cpu_const): LSU op codes (IDLE/BYTE/HALF/WORD), bus command codes (NONE/READ/WRITE), FSM state encodings.
- One sub-module, mem_lane_align: combinational store-lane replication + ben generation, and load lane extraction + extension.
- FSM and pipeline registers stay in mem_access.

Test Plan:
- Non-LSU pass-through: rd_no=7, alu_result=0x1234 -> next cycle o_rd_no=7, o_rd_val=0x1234, no bus cmd, stall 0.
- Store byte: addr=0x103, data=0xAABBCCDD, ack after 2 cycles -> addr=0x100, ben=1000, wdata=0xDDDDDDDD; stall high until ack; o_rd_no=0.
- Load half signed: addr=0x202, ext=1, rdata=0x8001FFFF -> o_rd_val=0xFFFF8001. Repeat with ext=0 -> 0x00008001.
- Misaligned word load at 0x301 -> o_addr_error one-cycle pulse, no dbus cmd, o_rd_no=0.
- Load completes (rvalid) while i_exec_stall=1 for 3 cycles -> state DONE; exactly one READ issued; result committed on the first cycle exec_stall=0.
- nrst low during WAIT -> next cycle all outputs at reset values, state IDLE; a following load proceeds normally.
